// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first; multi-byte frames stay under one CS until the byte flagged last.
// Define SPI_MASTER_RX_EN to build the MISO receive path; without it DOUT stays 0 and DRDY is a byte-done strobe.
module spi_master #(
   parameter int unsigned CLKDIV   = 2,
   parameter int unsigned CS_SETUP = 1,
   parameter int unsigned CS_HOLD  = 1
) (
   input  logic       i_sysclk,
   input  logic       i_resetn,
   input  logic [7:0] i_din,
   input  logic       i_dvalid,
   input  logic       i_dlast,
   output logic       o_dready,
   output logic [7:0] o_dout,
   output logic       o_drdy,
   output logic       o_busy,
   output logic       o_sck,
   output logic       o_mosi,
   input  logic       i_miso,
   output logic       o_cs
);
   localparam int unsigned SETUP_CYC = CS_SETUP * CLKDIV;
   localparam int unsigned HOLD_CYC  = CS_HOLD * CLKDIV;
   localparam int unsigned MAX_A     = (SETUP_CYC > CLKDIV) ? SETUP_CYC : CLKDIV;
   localparam int unsigned MAX_CYC   = (HOLD_CYC > MAX_A) ? HOLD_CYC : MAX_A;
   localparam int unsigned CW        = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0] HALF_LAST  = CW'(CLKDIV - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

   // LEAD is the CLKDIV-cycle MOSI lead-in after a byte is accepted in WAIT.
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_LEAD, S_SHIFT, S_HOLD, S_GAP} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_bit;
   logic [6:0]    r_tx;
   logic          r_last;
   logic          r_cs;
   logic          r_sck;
   logic          r_mosi;
   logic          r_busy;
   logic          r_drdy;
   logic          w_accept;
   logic          w_half_end;
   logic          w_byte_done;

   assign o_dready    = (r_state == S_IDLE) || (r_state == S_WAIT);
   assign w_accept    = i_dvalid && o_dready;
   assign w_half_end  = (r_cnt == HALF_LAST);
   assign w_byte_done = (r_state == S_SHIFT) && w_half_end && (r_bit == 4'd14);

   assign o_cs   = r_cs;
   assign o_sck  = r_sck;
   assign o_mosi = r_mosi;
   assign o_busy = r_busy;
   assign o_drdy = r_drdy;

   // r_bit is the current half-period index: SCK is high on even indices.
   always_ff @(posedge i_sysclk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_tx    <= '0;
         r_last  <= 1'b0;
         r_cs    <= 1'b1;
         r_sck   <= 1'b0;
         r_mosi  <= 1'b0;
         r_busy  <= 1'b0;
         r_drdy  <= 1'b0;
      end else begin
         r_drdy <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cs    <= 1'b0;
                  r_mosi  <= i_din[7];
                  r_tx    <= i_din[6:0];
                  r_last  <= i_dlast;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_sck   <= 1'b1;
                  r_state <= S_SHIFT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (w_accept) begin
                  r_mosi  <= i_din[7];
                  r_tx    <= i_din[6:0];
                  r_last  <= i_dlast;
                  r_cnt   <= '0;
                  r_state <= S_LEAD;
               end
            end
            S_LEAD: begin
               if (w_half_end) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_sck   <= 1'b1;
                  r_state <= S_SHIFT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_SHIFT: begin
               if (w_half_end) begin
                  r_cnt <= '0;
                  if (r_bit == 4'd15) begin
                     r_state <= r_last ? S_HOLD : S_WAIT;
                  end else begin
                     r_bit <= r_bit + 4'd1;
                     r_sck <= ~r_sck;
                     if (!r_bit[0]) begin
                        if (r_bit == 4'd14) begin
                           r_drdy <= 1'b1;
                        end else begin
                           r_mosi <= r_tx[6];
                           r_tx   <= {r_tx[5:0], 1'b0};
                        end
                     end
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cnt   <= '0;
                  r_cs    <= 1'b1;
                  r_state <= S_GAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (w_half_end) begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_mosi  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SPI_MASTER_RX_EN
   logic [7:0] r_rx;
   logic [7:0] r_dout;
   logic       w_rise;

   // SCK rises on entry to SHIFT and at the end of every odd half-period except the last.
   assign w_rise = ((r_state == S_SETUP) && (r_cnt == SETUP_LAST)) ||
                   ((r_state == S_LEAD) && w_half_end) ||
                   ((r_state == S_SHIFT) && w_half_end && r_bit[0] && (r_bit != 4'd15));

   always_ff @(posedge i_sysclk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_rx   <= '0;
         r_dout <= '0;
      end else begin
         if (w_rise) begin
            r_rx <= {r_rx[6:0], i_miso};
         end
         if (w_byte_done) begin
            r_dout <= r_rx;
         end
      end
   end

   assign o_dout = r_dout;
`else
   logic w_unused_miso;
   assign w_unused_miso = i_miso;
   assign o_dout        = 8'h00;
`endif

endmodule
